// File: rtl/dma_requester_pkg.sv
// Shared types and constants for the DMA requester channel endpoint.
package dma_requester_pkg;

    // Channel handshake state, walked once per single-mode transfer.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQUEST = 3'd1,
        ST_ACK     = 3'd2,
        ST_RECOVER = 3'd3,
        ST_DONE    = 3'd4
    } dma_req_state_t;

    // Value of the direction input for each transfer sense.
    localparam logic DIR_DEV_TO_MEM = 1'b1;  // bus reads us with IOR#
    localparam logic DIR_MEM_TO_DEV = 1'b0;  // bus writes us with IOW#

endpackage

// File: rtl/dma_requester_fifo.sv
// Byte-wide synchronous FIFO with a separate occupancy counter.
// Overflowing pushes and underflowing pops are dropped silently.
module dma_requester_fifo #(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [7:0]            push_data,
    input  logic                  pop,
    output logic [7:0]            head_data,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   level
);

    localparam logic [ADDR_WIDTH:0] FULL_LEVEL = DEPTH[ADDR_WIDTH:0];

    logic [7:0]            mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full      = (level == FULL_LEVEL);
    assign empty     = (level == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    // Storage array write.
    // NOTE: the data array has no reset; a stale byte is never visible because
    // readers qualify the head with empty, and resetting it would cost a mux per bit.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    // NOTE: clocked state uses <= so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/dma_requester.sv
// DREQ/DACK requester endpoint for one single-mode DMA channel. Bytes move
// between a device-side valid/ready stream and the ISA-style bus through a FIFO;
// a bus transfer completes on the rising edge of IOR#/IOW# while DACK is low.
module dma_requester
    import dma_requester_pkg::*;
#(
    parameter int FIFO_DEPTH      = 16,
    parameter int FIFO_ADDR_WIDTH = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic                       direction,
    output logic                       dma_request,
    input  logic                       dma_acknowledge_n,
    input  logic                       io_read_n,
    input  logic                       io_write_n,
    input  logic                       terminal_count_n,
    input  logic [7:0]                 data_bus_in,
    output logic [7:0]                 data_bus_out,
    output logic                       data_bus_out_enable,
    input  logic                       dev_in_valid,
    input  logic [7:0]                 dev_in_data,
    output logic                       dev_in_ready,
    output logic                       dev_out_valid,
    output logic [7:0]                 dev_out_data,
    input  logic                       dev_out_ready,
    output logic [FIFO_ADDR_WIDTH:0]   fifo_level,
    output logic                       block_done,
    input  logic                       clear_done
);

    dma_req_state_t state;
    dma_req_state_t state_next;

    logic       dev_to_mem;
    logic       prev_ior_n;
    logic       prev_iow_n;
    logic       ior_rise;
    logic       iow_rise;
    logic       xfer_done;
    logic       strobe_low;
    logic [7:0] wdata_q;
    logic       live;
    logic       tc_pending;
    logic       xfer_seen;
    logic       tc_commit;
    logic       can_xfer;

    logic       fifo_push;
    logic       fifo_pop;
    logic [7:0] fifo_push_data;
    logic [7:0] fifo_head;
    logic       fifo_full;
    logic       fifo_empty;

    assign dev_to_mem = (direction == DIR_DEV_TO_MEM);

    // A completed bus cycle is the strobe's low-to-high edge seen under DACK.
    assign ior_rise   = !prev_ior_n && io_read_n;
    assign iow_rise   = !prev_iow_n && io_write_n;
    assign xfer_done  = !dma_acknowledge_n && (dev_to_mem ? ior_rise : iow_rise);
    assign strobe_low = dev_to_mem ? !io_read_n : !io_write_n;
    assign tc_commit  = tc_pending && xfer_seen;
    assign can_xfer   = dev_to_mem ? !fifo_empty : !fifo_full;

    // Strobe history, write-data capture while IOW# is low, and the out-of-reset flag
    // that keeps input-derived outputs quiet while reset_n is held.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_ior_n <= 1'b1;
            prev_iow_n <= 1'b1;
            wdata_q    <= 8'h00;
            live       <= 1'b0;
        end else begin
            prev_ior_n <= io_read_n;
            prev_iow_n <= io_write_n;
            if (!io_write_n) wdata_q <= data_bus_in;
            live       <= 1'b1;
        end
    end

    // Route the FIFO ports according to the transfer sense.
    // NOTE: every output of a combinational block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        fifo_push      = 1'b0;
        fifo_pop       = 1'b0;
        fifo_push_data = 8'h00;
        if (dev_to_mem) begin
            fifo_push      = dev_in_valid && dev_in_ready;
            fifo_push_data = dev_in_data;
            fifo_pop       = xfer_done;
        end else begin
            fifo_push      = xfer_done;
            fifo_push_data = wdata_q;
            fifo_pop       = dev_out_valid && dev_out_ready;
        end
    end

    dma_requester_fifo #(
        .DEPTH      (FIFO_DEPTH),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign dev_in_ready        = live && dev_to_mem && !fifo_full;
    assign dev_out_valid       = !dev_to_mem && !fifo_empty;
    assign dev_out_data        = fifo_empty ? 8'h00 : fifo_head;
    assign data_bus_out        = (dev_to_mem && !fifo_empty) ? fifo_head : 8'h00;
    assign data_bus_out_enable = live && dev_to_mem && !dma_acknowledge_n && !io_read_n;

    // Handshake state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Next-state logic; DREQ is a Moore output of REQUEST.
    always_comb begin
        state_next  = state;
        dma_request = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable && !block_done && can_xfer) state_next = ST_REQUEST;
            end
            ST_REQUEST: begin
                dma_request = 1'b1;
                if (!enable)                 state_next = ST_IDLE;
                else if (!dma_acknowledge_n) state_next = ST_ACK;
            end
            ST_ACK: begin
                if (!enable)                             state_next = ST_IDLE;
                else if (xfer_done || dma_acknowledge_n) state_next = ST_RECOVER;
            end
            ST_RECOVER: begin
                state_next = tc_commit ? ST_DONE : ST_IDLE;
            end
            ST_DONE: begin
                if (clear_done) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Terminal-count capture during ACK; it only counts if the strobe then completes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tc_pending <= 1'b0;
            xfer_seen  <= 1'b0;
        end else if (state == ST_ACK) begin
            if (!terminal_count_n && strobe_low) tc_pending <= 1'b1;
            if (xfer_done)                       xfer_seen  <= 1'b1;
        end else if (state != ST_RECOVER) begin
            tc_pending <= 1'b0;
            xfer_seen  <= 1'b0;
        end
    end

    // Sticky end-of-block flag, set on leaving RECOVER after a TC transfer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            block_done <= 1'b0;
        end else if (state == ST_RECOVER && tc_commit) begin
            block_done <= 1'b1;
        end else if (clear_done) begin
            block_done <= 1'b0;
        end
    end

endmodule

// File: doc/dma_requester.md
Name: dma_requester

Overview:
- DMA-capable peripheral endpoint: the requester side of the 8237-style DREQ/DACK handshake driven by the bus arbiter.
- Buffers bytes between a device-side stream and the system bus in a FIFO.
- Raises dma_request, then transfers one byte per DACK cycle on the IOR#/IOW# strobe.
- Recognises terminal count to end a block. Sits on one DMA channel (e.g. floppy/disk data port), single-transfer mode.

Parameters:
- FIFO_DEPTH, 16, byte entries in buffer; power of two, ≥2.
- FIFO_ADDR_WIDTH, 4, log2(FIFO_DEPTH).

Ports:
- clock  in  1  system clock; all logic rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  channel armed; low forces IDLE, no request.
- direction  in  1  1 = device→memory (bus reads us via io_read_n); 0 = memory→device (bus writes us via io_write_n).
- dma_request  out  1  DREQ to arbiter.
- dma_acknowledge_n  in  1  DACK for this channel.
- io_read_n  in  1  bus IOR# strobe.
- io_write_n  in  1  bus IOW# strobe.
- terminal_count_n  in  1  TC from DMA controller.
- data_bus_in  in  8  bus data during IOW#.
- data_bus_out  out  8  FIFO head byte driven to bus.
- data_bus_out_enable  out  1  high while DACK low, io_read_n low, direction=1.
- dev_in_valid / dev_in_data[8] / dev_in_ready  in/in/out  device→FIFO push port (direction=1).
- dev_out_valid / dev_out_data[8] / dev_out_ready  out/out/in  FIFO→device pop port (direction=0).
- fifo_level  out  FIFO_ADDR_WIDTH+1  current occupancy.
- block_done  out  1  sticky; set by TC transfer.
- clear_done  in  1  clears block_done, returns to IDLE.

Behaviour:
- Reset: dma_request=0, data_bus_out=0, data_bus_out_enable=0, dev_in_ready=0, dev_out_valid=0, fifo_level=0, block_done=0, state IDLE, strobe history regs=1.
- Strobe edge detection: register io_read_n, io_write_n each cycle. A transfer completes on the rising edge (prev=0, cur=1) of the relevant strobe while dma_acknowledge_n=0. Strobe edges without DACK are ignored.
- FSM states:
  - IDLE → REQUEST when enable=1, block_done=0, and transfer possible (direction=1: fifo_level>0; direction=0: fifo_level<FIFO_DEPTH).
  - REQUEST: dma_request=1; held until dma_acknowledge_n=0 is sampled, then → ACK.
  - ACK: dma_request=0 (single mode). Wait for strobe rising edge → RECOVER. If DACK deasserts with no strobe edge → RECOVER, no FIFO change.
  - RECOVER: one mandatory cycle with dma_request=0; → DONE if TC was latched, else → IDLE.
  - DONE: dma_request=0 until clear_done=1 → IDLE.
- TC latch: terminal_count_n sampled low at any cycle in ACK with the strobe low → TC flag. Flag is acted on only if the strobe completes; block_done sets in RECOVER.
- direction=1: data_bus_out = FIFO head (combinational from read pointer). Pop on IOR# rising edge. dev_in_ready = (fifo_level<FIFO_DEPTH).
- direction=0: on IOW# rising edge, push data_bus_in captured at the previous sample while io_write_n was low (register data each cycle strobe is low). dev_out_valid = (fifo_level>0); pop on dev_out_valid & dev_out_ready.
- Simultaneous push and pop in one cycle: both pointers advance, fifo_level unchanged. Push when full is ignored (cannot occur by construction); pop when empty is ignored.
- Pointers wrap modulo FIFO_DEPTH; fifo_level is a separate counter of width FIFO_ADDR_WIDTH+1.
- enable low mid-transfer: dma_request drops next cycle and state → IDLE; a strobe already in progress under DACK still completes its FIFO action.
- direction changes only while enable=0. Changing it otherwise is unsupported; the FIFO is not flushed.
- reset_n assertion mid-operation: immediate clear of all state, FIFO contents discarded.
- Latency: DREQ rises the cycle after the IDLE condition holds. Minimum two cycles from a completed strobe to the next DREQ.

Decomposition:
- Shared package: dma_req_state_t enum (IDLE, REQUEST, ACK, RECOVER, DONE) and DIR_DEV_TO_MEM / DIR_MEM_TO_DEV constants.
- One sub-module: dma_requester_fifo (sync FIFO: push/pop/full/empty/level, parameterised depth).

Test Plan:
- Push 0x5A, 0xA5 from device (direction=1) → dma_request=1 after 1 cycle. DACK low, IOR# low: data_bus_out=0x5A, data_bus_out_enable=1. IOR# rise → fifo_level=1, DREQ re-asserts after RECOVER and one IDLE cycle, second read yields 0xA5.
- direction=0, empty FIFO → DREQ=1. DACK + IOW# with data_bus_in=0x3C → fifo_level=1, dev_out_data=0x3C. Fill to 16 → DREQ stays 0 until device pops.
- TC: on the 3rd transfer, hold terminal_count_n=0 during IOR# → block_done=1, DREQ stays 0 despite a non-empty FIFO. clear_done → DREQ=1 again.
- IOR# pulse with dma_acknowledge_n=1 → no pop, fifo_level unchanged. DACK low then high with no strobe → no FIFO change, returns to IDLE.
- Simultaneous device push and bus pop at fifo_level=4 → level remains 4, byte order preserved across pointer wrap (push 20 bytes total).
- Assert reset_n=0 while in ACK with 5 bytes buffered → all outputs at reset values within the same cycle, fifo_level=0.
